lcd_spi_target: RTL and testbench
=================================

# lcd_spi_target

SPI target (responder) for the 3-wire/4-wire LCD command bus driven by the `lcd_spi` master in `nios2_system`. It oversamples SCLK, SS_n and MOSI in the system clock domain and decodes each frame into 9-bit (D/C + byte) or 8-bit words. Decoded words are delivered through a small FIFO on a valid/ready stream, and optional read-back data is shifted out on MISO. It serves as the LCD-side endpoint for loopback bring-up and as an in-fabric LCD command sniffer.

## Interface
- `DC_BIT`, 1: 1 = 9-bit words (first bit is D/C); 0 = 8-bit words, `rx_dc` tied 0.
- `FIFO_DEPTH`, 4: receive FIFO entries; power of 2, range 2..16.
- `clk_clk` in 1: system clock; SCLK must be ≤ `clk_clk`/8.
- `reset_reset_n` in 1: asynchronous, active-low reset.
- `spi_sclk` in 1: SPI clock from master, asynchronous.
- `spi_ss_n` in 1: active-low select, asynchronous.
- `spi_mosi` in 1: serial data in, asynchronous.
- `spi_miso` out 1: serial read data.
- `spi_miso_oe` out 1: MISO output enable, high while selected.
- `rx_valid` out 1: FIFO head valid.
- `rx_ready` in 1: consumer accepts the head on `rx_valid & rx_ready`.
- `rx_dc` out 1: D/C of head word (0 = command, 1 = data).
- `rx_data` out 8: payload of head word.
- `tx_data` in 8: read-back byte.
- `tx_valid` in 1: `tx_data` is available.
- `tx_ready` out 1: single-cycle pulse when `tx_data` is captured.
- `busy` out 1: synchronized SS_n is low.
- `overflow` out 1: sticky; a word was dropped because the FIFO was full.
- `ovf_clear` in 1: clears `overflow`.
- `frame_abort` out 1: single-cycle pulse when SS_n rises with a partial word.

## Operation
- **Synchronization:** SCLK, SS_n and MOSI each pass through a 2-FF synchronizer plus one history register. Edges are detected on the synchronized value. Mode 0 (CPOL=0, CPHA=0), MSB first.
- **FSM states:**
  - IDLE: SS_n high.
  - SHIFT: SS_n low; sample MOSI on each detected SCLK rise.
  - Transitions: IDLE→SHIFT on SS_n falling. SHIFT→IDLE on SS_n rising.
- **Word assembly:**
  - Bit counter runs 0..W-1, where W = 8+`DC_BIT`.
  - On the rise that completes bit W-1, the word is pushed and the counter wraps to 0. Multiple words per frame are allowed.
  - 9-bit mode: the first bit is `rx_dc`, the next 8 bits form `rx_data` MSB first.
- **FIFO:**
  - Registered outputs; order is preserved.
  - Push while full: the word is dropped, the FIFO is unchanged, `overflow` is set.
  - Simultaneous push and pop while full: the pop frees the slot and the push succeeds, with no overflow.
  - Simultaneous push and pop while empty: no bypass; `rx_valid` rises the next cycle.
- **Overflow flag:**
  - `ovf_clear` and a new overflow in the same cycle: `overflow` stays 1 (set wins).
- **Abort:**
  - SS_n rising with bit counter ≠ 0: discard the partial word, pulse `frame_abort`, reset the counter.
  - SS_n rising with counter = 0: no pulse.
  - SCLK edges while SS_n is high are ignored.
- **Read-back:**
  - At word start (SS_n fall, or the counter wrapping to 0), load the TX shift register:
    - if `tx_valid`: from `tx_data`, and pulse `tx_ready`;
    - otherwise: 0x00.
  - 9-bit mode: MISO drives 0 during the D/C bit, then the byte MSB first.
  - The register shifts on each detected SCLK fall.
  - `spi_miso` = shift MSB when `busy`, else 0.
  - `spi_miso_oe` = `busy`.
- **Reset:** asynchronous; clears synchronizers, FIFO, counter, FSM and flags. Reset mid-frame loses any partial word. After release, reception starts only on the next SS_n falling edge.

## Timing
- **Reset values:**
  - `rx_valid`=0, `rx_dc`=0, `rx_data`=0x00
  - `spi_miso`=0, `spi_miso_oe`=0
  - `tx_ready`=0, `busy`=0
  - `overflow`=0, `frame_abort`=0
  - Synchronizers reset to idle levels: SCLK=0, SS_n=1, MOSI=0.
- **Receive latency:** `rx_valid` rises exactly 4 `clk_clk` cycles after the clock edge at which the pin-level final SCLK rise is first sampled (2 sync + 1 edge detect + 1 FIFO write). Same for `overflow` set.
- **Pop:** `rx_valid`/`rx_data` update on the cycle after a pop. Back-to-back pops are sustained at 1 word/cycle.
- **Select/abort latency:** `busy` follows pin SS_n with 2-cycle latency. `frame_abort` fires 3 cycles after SS_n rises at the pin.
- **MISO latency:** MISO changes 3 cycles after the pin SCLK fall (or the SS_n fall for the first bit). Hence the requirement SCLK half-period ≥ 4 `clk_clk`.

## Test plan
- **Reset:** assert `reset_reset_n`=0 mid-frame with random pins → all outputs at reset values. After release, a full frame 0x0_2A decodes correctly.
- **Single command:** 9-bit frame D/C=0, byte 0x2A, SCLK=`clk_clk`/8, `rx_ready`=1 → one word `rx_dc`=0, `rx_data`=0x2A. `rx_valid` high for exactly 1 cycle, 4 cycles after the last rise.
- **Overflow:** one frame of 6 words (0x2C cmd, then data 0x11..0x15) with `rx_ready`=0, `FIFO_DEPTH`=4 → `overflow`=1 after word 5. Draining yields 0x2C, 0x11, 0x12, 0x13 in order. `ovf_clear` → `overflow`=0.
- **Abort:** SS_n rises after 5 bits → one `frame_abort` pulse, no word pushed. The next frame (D/C=1, 0xA5) decodes as `rx_dc`=1, 0xA5.
- **Read-back:** `tx_data`=0xC3, `tx_valid`=1 before SS_n fall → `tx_ready` pulses once. Master samples MISO bits 0,1,1,0,0,0,0,1,1 on rising edges. The second word in the same frame with `tx_valid`=0 reads 0x00.
- **Boundary pop/push:** FIFO full, with `rx_ready`=1 on the exact cycle of the next push → no overflow, and the FIFO stays full with the new word at the tail.

Source files
------------

// File: rtl/lcd_spi_target.sv
// lcd_spi_target: oversampling SPI target for the LCD command bus.
// Decodes mode-0 frames into 9-bit (D/C + byte) or 8-bit words, queues them
// in a small FIFO with registered outputs, and shifts read-back data on MISO.
module lcd_spi_target #(
    parameter int unsigned DC_BIT     = 1,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic       clk_clk,
    input  logic       reset_reset_n,
    input  logic       spi_sclk,
    input  logic       spi_ss_n,
    input  logic       spi_mosi,
    output logic       spi_miso,
    output logic       spi_miso_oe,
    output logic       rx_valid,
    input  logic       rx_ready,
    output logic       rx_dc,
    output logic [7:0] rx_data,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic       busy,
    output logic       overflow,
    input  logic       ovf_clear,
    output logic       frame_abort
);

    localparam int unsigned W     = 8 + DC_BIT;
    localparam int unsigned CNT_W = 4;
    localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
    localparam int unsigned LVL_W = PTR_W + 1;

    typedef enum logic {IDLE = 1'b0, SHIFT = 1'b1} state_t;

    // synchronizers, history registers and registered edge strobes
    logic       sclk_s1, sclk_s2, sclk_d;
    logic       ss_s1, ss_s2, ss_d;
    logic       mosi_s1, mosi_s2, mosi_d;
    logic       sclk_rise_q, sclk_fall_q, ss_fall_q, ss_rise_q;
    logic [1:0] sync_fill;
    logic       armed;

    // frame decoder state
    state_t           state, state_n;
    logic [CNT_W-1:0] bit_cnt, bit_cnt_n;
    logic [W-1:0]     rx_sh, rx_sh_n;
    logic [W-1:0]     tx_sh, tx_sh_n;
    logic [W-1:0]     tx_load;
    logic             push_q, push_n;
    logic [8:0]       push_word, push_word_n;
    logic             tx_ready_n, abort_n, miso_n;

    // FIFO
    logic [8:0]       mem [FIFO_DEPTH];
    logic [PTR_W-1:0] rd_ptr, wr_ptr, rd_n, wr_n;
    logic [LVL_W-1:0] level, level_n;
    logic             pop, full, wr_en, ovf_set;
    logic [8:0]       head_n;

    // Pin synchronization; a fall is only trusted once SS_n has been seen high
    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            sclk_s1     <= 1'b0;
            sclk_s2     <= 1'b0;
            sclk_d      <= 1'b0;
            ss_s1       <= 1'b1;
            ss_s2       <= 1'b1;
            ss_d        <= 1'b1;
            mosi_s1     <= 1'b0;
            mosi_s2     <= 1'b0;
            mosi_d      <= 1'b0;
            sclk_rise_q <= 1'b0;
            sclk_fall_q <= 1'b0;
            ss_fall_q   <= 1'b0;
            ss_rise_q   <= 1'b0;
            sync_fill   <= 2'b00;
            armed       <= 1'b0;
        end else begin
            sclk_s1     <= spi_sclk;
            sclk_s2     <= sclk_s1;
            sclk_d      <= sclk_s2;
            ss_s1       <= spi_ss_n;
            ss_s2       <= ss_s1;
            ss_d        <= ss_s2;
            mosi_s1     <= spi_mosi;
            mosi_s2     <= mosi_s1;
            mosi_d      <= mosi_s2;
            sclk_rise_q <= sclk_s2 & ~sclk_d;
            sclk_fall_q <= ~sclk_s2 & sclk_d;
            ss_fall_q   <= armed & ss_d & ~ss_s2;
            ss_rise_q   <= ss_s2 & ~ss_d;
            sync_fill   <= {sync_fill[0], 1'b1};
            armed       <= armed | (sync_fill[1] & ss_s2);
        end
    end

    // Decoder registers
    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            state       <= IDLE;
            bit_cnt     <= '0;
            rx_sh       <= '0;
            tx_sh       <= '0;
            push_q      <= 1'b0;
            push_word   <= '0;
            tx_ready    <= 1'b0;
            frame_abort <= 1'b0;
            spi_miso    <= 1'b0;
            busy        <= 1'b0;
        end else begin
            state       <= state_n;
            bit_cnt     <= bit_cnt_n;
            rx_sh       <= rx_sh_n;
            tx_sh       <= tx_sh_n;
            push_q      <= push_n;
            push_word   <= push_word_n;
            tx_ready    <= tx_ready_n;
            frame_abort <= abort_n;
            spi_miso    <= miso_n;
            busy        <= ~ss_s1;
        end
    end

    assign spi_miso_oe = busy;
    assign tx_load     = W'(tx_valid ? tx_data : 8'h00);

    // Next-state: frame tracking, word assembly and read-back shifting
    always_comb begin
        state_n     = state;
        bit_cnt_n   = bit_cnt;
        rx_sh_n     = rx_sh;
        tx_sh_n     = tx_sh;
        push_n      = 1'b0;
        push_word_n = push_word;
        tx_ready_n  = 1'b0;
        abort_n     = 1'b0;
        case (state)
            IDLE: begin
                if (ss_fall_q) begin
                    state_n    = SHIFT;
                    bit_cnt_n  = '0;
                    tx_sh_n    = tx_load;
                    tx_ready_n = tx_valid;
                end
            end
            SHIFT: begin
                if (ss_rise_q) begin
                    state_n   = IDLE;
                    bit_cnt_n = '0;
                    tx_sh_n   = '0;
                    abort_n   = (bit_cnt != '0);
                end else if (sclk_rise_q) begin
                    rx_sh_n = {rx_sh[W-2:0], mosi_d};
                    if (bit_cnt == CNT_W'(W - 1)) begin
                        bit_cnt_n        = '0;
                        push_n           = 1'b1;
                        push_word_n[7:0] = rx_sh_n[7:0];
                        push_word_n[8]   = (DC_BIT != 0) ? rx_sh_n[W-1] : 1'b0;
                        tx_sh_n          = tx_load;
                        tx_ready_n       = tx_valid;
                    end else begin
                        bit_cnt_n = bit_cnt + CNT_W'(1);
                    end
                end else if (sclk_fall_q && (bit_cnt != '0)) begin
                    // the fall right after a word boundary keeps the freshly loaded MSB
                    tx_sh_n = {tx_sh[W-2:0], 1'b0};
                end
            end
            default: state_n = IDLE;
        endcase
        miso_n = ~ss_s1 & tx_sh_n[W-1];
    end

    // FIFO control; a pop frees a full slot for a same-cycle push
    always_comb begin
        pop     = rx_valid & rx_ready;
        full    = (level == LVL_W'(FIFO_DEPTH));
        wr_en   = push_q & (~full | pop);
        ovf_set = push_q & full & ~pop;
        level_n = level + LVL_W'(wr_en) - LVL_W'(pop);
        rd_n    = rd_ptr + PTR_W'(pop);
        wr_n    = wr_ptr + PTR_W'(wr_en);
        head_n  = (wr_en && (wr_ptr == rd_n)) ? push_word : mem[rd_n];
    end

    // FIFO pointers, registered head and sticky overflow
    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            level    <= '0;
            rx_valid <= 1'b0;
            rx_dc    <= 1'b0;
            rx_data  <= 8'h00;
            overflow <= 1'b0;
        end else begin
            rd_ptr   <= rd_n;
            wr_ptr   <= wr_n;
            level    <= level_n;
            rx_valid <= (level_n != '0);
            if (level_n != '0) begin
                rx_dc   <= head_n[8];
                rx_data <= head_n[7:0];
            end
            overflow <= ovf_set | (overflow & ~ovf_clear);
        end
    end

    // FIFO storage
    always_ff @(posedge clk_clk) begin
        if (wr_en) begin
            mem[wr_ptr] <= push_word;
        end
    end

endmodule

// File: tb/tb_lcd_spi_target.sv
// tb_lcd_spi_target: directed and randomized frames against a queue-based model.
module tb_lcd_spi_target;

    localparam int unsigned W     = 9;
    localparam int unsigned DEPTH = 4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       sclk = 1'b0;
    logic       ss_n = 1'b1;
    logic       mosi = 1'b0;
    logic       miso, miso_oe;
    logic       rx_valid, rx_dc;
    logic [7:0] rx_data;
    logic       rx_ready = 1'b0;
    logic [7:0] tx_data = 8'h00;
    logic       tx_valid = 1'b0;
    logic       tx_ready, busy, overflow, frame_abort;
    logic       ovf_clear = 1'b0;

    lcd_spi_target #(.DC_BIT(1), .FIFO_DEPTH(DEPTH)) dut (
        .clk_clk(clk), .reset_reset_n(rst_n),
        .spi_sclk(sclk), .spi_ss_n(ss_n), .spi_mosi(mosi),
        .spi_miso(miso), .spi_miso_oe(miso_oe),
        .rx_valid(rx_valid), .rx_ready(rx_ready), .rx_dc(rx_dc), .rx_data(rx_data),
        .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
        .busy(busy), .overflow(overflow), .ovf_clear(ovf_clear),
        .frame_abort(frame_abort)
    );

    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // observed traffic
    logic [8:0]  got_q[$];
    logic [8:0]  exp_q[$];
    int unsigned abort_cnt = 0, txr_cnt = 0, valid_hi_cnt = 0;
    int unsigned first_valid_cyc = 0, abort_cyc = 0;
    logic        valid_prev = 1'b0;

    always @(negedge clk) begin
        if (rx_valid && rx_ready) got_q.push_back({rx_dc, rx_data});
        if (rx_valid) valid_hi_cnt <= valid_hi_cnt + 1;
        if (rx_valid && !valid_prev) first_valid_cyc <= cyc;
        valid_prev <= rx_valid;
        if (frame_abort) begin
            abort_cnt <= abort_cnt + 1;
            abort_cyc <= cyc;
        end
        if (tx_ready) txr_cnt <= txr_cnt + 1;
    end

    int total = 0;
    int bad = 0;
    int unsigned rise_cyc = 0, ss_rise_cyc = 0;

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic check_reset(input string tag);
        check({tag, "_rx_valid"}, 32'(rx_valid), 32'h0);
        check({tag, "_rx_dc"}, 32'(rx_dc), 32'h0);
        check({tag, "_rx_data"}, 32'(rx_data), 32'h0);
        check({tag, "_miso"}, 32'(miso), 32'h0);
        check({tag, "_miso_oe"}, 32'(miso_oe), 32'h0);
        check({tag, "_tx_ready"}, 32'(tx_ready), 32'h0);
        check({tag, "_busy"}, 32'(busy), 32'h0);
        check({tag, "_overflow"}, 32'(overflow), 32'h0);
        check({tag, "_abort"}, 32'(frame_abort), 32'h0);
    endtask

    // compare everything the consumer popped against the model, then clear both
    task automatic expect_words(input string tag);
        check({tag, "_count"}, 32'(got_q.size()), 32'(exp_q.size()));
        for (int i = 0; i < exp_q.size(); i++) begin
            if (i < got_q.size()) check({tag, "_word"}, 32'(got_q[i]), 32'(exp_q[i]));
        end
        got_q.delete();
        exp_q.delete();
    endtask

    // master side: mode 0, MSB first, SCLK half-period of 4 clocks
    task automatic send_word(input logic [8:0] w, input int nbits, output logic [8:0] mw);
        mw = '0;
        for (int i = 0; i < nbits; i++) begin
            mosi = w[W-1-i];
            tick(4);
            mw[W-1-i] = miso;
            sclk = 1'b1;
            rise_cyc = cyc;
            tick(4);
            sclk = 1'b0;
        end
    endtask

    task automatic frame_begin();
        ss_n = 1'b0;
        tick(6);
    endtask

    task automatic frame_end();
        tick(4);
        ss_n = 1'b1;
        ss_rise_cyc = cyc;
        tick(8);
    endtask

    initial begin
        logic [8:0]  mw, w;
        logic [8:0]  words[6];
        int unsigned r0, v0, a0, t0, nw;
        logic        txv;
        logic [7:0]  txd;

        // power-on reset
        tick(3);
        check_reset("por");
        rst_n = 1'b1;
        tick(5);

        // single command word with latency and pulse width
        rx_ready = 1'b1;
        a0 = abort_cnt;
        v0 = valid_hi_cnt;
        frame_begin();
        check("sel_busy", 32'(busy), 32'h1);
        check("sel_oe", 32'(miso_oe), 32'h1);
        send_word(9'h02A, 9, mw);
        r0 = rise_cyc;
        exp_q.push_back(9'h02A);
        frame_end();
        check("single_latency", first_valid_cyc - r0, 32'd5);
        check("single_width", valid_hi_cnt - v0, 32'd1);
        check("single_no_abort", abort_cnt - a0, 32'd0);
        check("idle_busy", 32'(busy), 32'h0);
        expect_words("single");

        // abort after 5 bits, then a clean data word
        a0 = abort_cnt;
        frame_begin();
        send_word(9'h1FF, 5, mw);
        frame_end();
        check("abort_pulses", abort_cnt - a0, 32'd1);
        check("abort_latency", abort_cyc - ss_rise_cyc, 32'd4);
        check("abort_rx_valid", 32'(rx_valid), 32'h0);
        frame_begin();
        send_word(9'h1A5, 9, mw);
        exp_q.push_back(9'h1A5);
        frame_end();
        expect_words("after_abort");

        // overflow: 6 words into a 4-deep FIFO with the consumer stalled
        rx_ready = 1'b0;
        words[0] = 9'h02C;
        for (int k = 1; k < 6; k++) words[k] = 9'h100 | 9'(8'h10 + k);
        frame_begin();
        for (int k = 0; k < 6; k++) begin
            send_word(words[k], 9, mw);
            if (k < int'(DEPTH)) exp_q.push_back(words[k]);
            if (k == 5) begin
                ovf_clear = 1'b1;
                tick(1);
                ovf_clear = 1'b0;
                check("ovf_set_wins", 32'(overflow), 32'h1);
            end else begin
                tick(2);
                check("ovf_after_word", 32'(overflow), 32'(k >= int'(DEPTH)));
            end
        end
        check("ovf_head_data", 32'(rx_data), 32'h2C);
        frame_end();
        rx_ready = 1'b1;
        tick(8);
        rx_ready = 1'b0;
        expect_words("ovf_drain");
        check("ovf_drained", 32'(rx_valid), 32'h0);
        ovf_clear = 1'b1;
        tick(1);
        ovf_clear = 1'b0;
        check("ovf_cleared", 32'(overflow), 32'h0);

        // full FIFO: pop on the exact cycle of the next push
        frame_begin();
        for (int k = 0; k < int'(DEPTH); k++) begin
            w = 9'($urandom);
            send_word(w, 9, mw);
            exp_q.push_back(w);
        end
        w = 9'($urandom);
        send_word(w, 9, mw);
        rx_ready = 1'b1;
        tick(1);
        rx_ready = 1'b0;
        exp_q.push_back(w);
        tick(2);
        check("bnd_no_ovf", 32'(overflow), 32'h0);
        check("bnd_one_popped", 32'(got_q.size()), 32'd1);
        check("bnd_valid", 32'(rx_valid), 32'h1);
        frame_end();
        rx_ready = 1'b1;
        tick(8);
        expect_words("bnd_drain");

        // read-back of 0xC3, then an empty second word
        tx_data = 8'hC3;
        tx_valid = 1'b1;
        t0 = txr_cnt;
        frame_begin();
        tx_valid = 1'b0;
        send_word(9'h02C, 9, mw);
        exp_q.push_back(9'h02C);
        check("rb_word0", 32'(mw), 32'h0C3);
        send_word(9'h155, 9, mw);
        exp_q.push_back(9'h155);
        check("rb_word1", 32'(mw), 32'h000);
        frame_end();
        check("rb_tx_ready", txr_cnt - t0, 32'd1);
        expect_words("rb");

        // randomized frames against the model
        for (int f = 0; f < 6; f++) begin
            nw  = $urandom_range(1, 3);
            txv = 1'($urandom_range(0, 1));
            txd = 8'($urandom);
            tx_data = txd;
            tx_valid = txv;
            t0 = txr_cnt;
            frame_begin();
            tx_valid = 1'b0;
            for (int j = 0; j < int'(nw); j++) begin
                w = 9'($urandom);
                send_word(w, 9, mw);
                exp_q.push_back(w);
                check("rnd_miso", 32'(mw), (j == 0 && txv) ? 32'(txd) : 32'h0);
            end
            frame_end();
            check("rnd_tx_ready", txr_cnt - t0, 32'(txv));
            expect_words("rnd");
        end

        // reset in the middle of a frame with random pin levels
        frame_begin();
        send_word(9'h1F0, 4, mw);
        sclk = 1'($urandom);
        mosi = 1'($urandom);
        ss_n = 1'($urandom);
        rst_n = 1'b0;
        #2;
        check_reset("midrst");
        tick(3);
        rst_n = 1'b1;
        tick(3);
        ss_n = 1'b1;
        sclk = 1'b0;
        mosi = 1'b0;
        tick(8);
        check("midrst_idle_valid", 32'(rx_valid), 32'h0);
        check("midrst_no_word", 32'(got_q.size()), 32'd0);
        frame_begin();
        send_word(9'h02A, 9, mw);
        exp_q.push_back(9'h02A);
        frame_end();
        expect_words("midrst_frame");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
